// File: rtl/decoder_nto2n_seq_pkg.sv
// Shared types and helpers for the sequenced N-to-2^N decoder.
package decoder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_e;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Widest output bus the helper below can build; callers truncate to OUT_W.
    localparam int unsigned MAX_OUT_W = 256;

    // One-hot bus of out_w lines with line idx asserted in the requested polarity.
    // Bits at and above out_w are always zero.
    function automatic logic [MAX_OUT_W-1:0] onehot(input int unsigned idx,
                                                    input int unsigned out_w,
                                                    input logic        active_low);
        logic [MAX_OUT_W-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < MAX_OUT_W; i++) begin
            if (i < out_w) v[i] = (i == idx) ^ active_low;
        end
        return v;
    endfunction

endpackage

// File: rtl/decoder_nto2n_seq_dwell_counter.sv
// Dwell timer for SCAN mode: counts 0..DWELL-1 while run is high.
module dwell_counter #(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic run,
    output logic tick
);
    localparam int CW = $clog2(DWELL + 1);
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // tick marks the final cycle of the current dwell window
    assign tick = run & (cnt_q == LAST);

    // clear wins over counting; the count wraps to 0 on tick
    always_comb begin
        cnt_d = cnt_q;
        if (clr)      cnt_d = '0;
        else if (run) cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    // count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/decoder_nto2n_seq.sv
// Registered binary-to-one-hot decoder with select handshake, range check,
// polarity select and an autonomous SCAN sweep.
module decoder_nto2n_seq
    import decoder_pkg::*;
#(
    parameter int SEL_W      = 3,
    parameter int OUT_W      = 8,
    parameter int DWELL      = 4,
    parameter int ACTIVE_LOW = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode,
    input  logic             sel_valid,
    input  logic [SEL_W-1:0] sel_in,
    output logic             sel_ready,
    output logic [OUT_W-1:0] data_out,
    output logic             out_valid,
    output logic [SEL_W-1:0] cur_idx,
    output logic             wrap,
    output logic             err
);
    localparam logic [OUT_W-1:0] INACTIVE = (ACTIVE_LOW != 0) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(OUT_W - 1);
    localparam logic [SEL_W:0]   OUT_W_EXT = (SEL_W + 1)'(OUT_W);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic [OUT_W-1:0] data_q, data_d, hot;
    logic             vld_q, vld_d, wrap_q, wrap_d, err_q, err_d;
    logic             accept, in_range, load, clr, run, tick;

    assign sel_ready = en & (mode == MODE_DIRECT);
    assign accept    = sel_valid & sel_ready;
    assign in_range  = {1'b0, sel_in} < OUT_W_EXT;

    // dwell runs only while staying in SCAN; any entry or exit restarts it
    assign clr = (state_q != SCAN) | (state_d != SCAN);
    assign run = ~clr;

    dwell_counter #(.DWELL(DWELL)) u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .run   (run),
        .tick  (tick)
    );

    // next state follows en/mode directly every cycle
    always_comb begin
        if (!en)                    state_d = IDLE;
        else if (mode == MODE_SCAN) state_d = SCAN;
        else                        state_d = DIRECT;
    end

    // next index / valid / pulses; load requests a fresh one-hot of idx_d
    always_comb begin
        idx_d  = idx_q;
        vld_d  = vld_q;
        data_d = data_q;
        wrap_d = 1'b0;
        err_d  = 1'b0;
        load   = 1'b0;
        unique case (state_d)
            IDLE: begin
                idx_d  = '0;
                vld_d  = 1'b0;
                data_d = INACTIVE;
            end
            DIRECT: begin
                // entering DIRECT blanks the bus; an accept in the same cycle still lands
                if (state_q != DIRECT) begin
                    idx_d  = '0;
                    vld_d  = 1'b0;
                    data_d = INACTIVE;
                end
                if (accept) begin
                    if (in_range) begin
                        idx_d = sel_in;
                        vld_d = 1'b1;
                        load  = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (state_q != SCAN) begin
                    idx_d = '0;
                    vld_d = 1'b1;
                    load  = 1'b1;
                end else if (tick) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d  = '0;
                        wrap_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                    vld_d = 1'b1;
                    load  = 1'b1;
                end
            end
            default: begin
                idx_d  = '0;
                vld_d  = 1'b0;
                data_d = INACTIVE;
            end
        endcase
        hot = OUT_W'(onehot(32'(idx_d), OUT_W, ACTIVE_LOW != 0));
        if (load) data_d = hot;
    end

    // state and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            data_q  <= INACTIVE;
            vld_q   <= 1'b0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    assign data_out  = data_q;
    assign out_valid = vld_q;
    assign cur_idx   = idx_q;
    assign wrap      = wrap_q;
    assign err       = err_q;

    // asserted lines in positive polarity, for the invariants below
    logic [OUT_W-1:0] lines;
    assign lines = data_q ^ INACTIVE;

    a_onehot_when_valid: assert property (@(posedge clk) disable iff (!rst_n)
        vld_q |-> $onehot(lines));
    a_none_when_invalid: assert property (@(posedge clk) disable iff (!rst_n)
        !vld_q |-> (lines == '0));

endmodule
